// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 master (CPOL=0, CPHA=0). One full-duplex transaction per accepted
//   i_start, MSB first. CS, SCLK and MOSI are all generated in the i_clk domain,
//   and MISO is sampled there as well, so setup, hold and gap times are plain
//   i_clk cycle counts.
//
// Ports
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_start     start request, accepted only while o_busy is low
//   i_tx_data   word to transmit, captured on the accepting edge
//   o_busy      high from acceptance until the end of the CS-high gap
//   o_rx_data   last complete word received on MISO
//   o_rx_done   one-cycle pulse when o_rx_data is updated (CS rises the same cycle)
//   o_spi_cs    chip select, active-low
//   o_spi_clk   SCLK, idles low
//   o_spi_mosi  master out, slave in
//   i_spi_miso  master in, slave out (ignored while CS is high)
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int DATA_WIDTH   = 8,
  parameter int HALF_PERIOD  = 4,
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_done,
  output logic                  o_spi_cs,
  output logic                  o_spi_clk,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
);

  // One shared phase counter serves every timed state, so it is sized for the
  // longest of the setup, half-period, hold and gap intervals.
  localparam int MAX_SH  = (SETUP_CYCLES > HALF_PERIOD) ? SETUP_CYCLES : HALF_PERIOD;
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = ((MAX_SH > MAX_HG) ? MAX_SH : MAX_HG) - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int BIT_W   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_done;
  logic                  r_busy;
  logic                  r_cs;
  logic                  r_sclk;
  logic                  r_mosi;

  state_t                w_state;
  logic [CNT_W-1:0]      w_cnt;
  logic [BIT_W-1:0]      w_bit;
  logic [DATA_WIDTH-1:0] w_tx;
  logic [DATA_WIDTH-1:0] w_rx;
  logic [DATA_WIDTH-1:0] w_rx_data;
  logic                  w_rx_done;
  logic                  w_busy;
  logic                  w_cs;
  logic                  w_sclk;
  logic                  w_mosi;

  // State and output registers. Every output comes straight from a flop, and
  // the async reset returns the wire to the idle CS-high/SCLK-low condition
  // immediately, discarding any partially received word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_rx_done <= 1'b0;
      r_busy    <= 1'b0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bit     <= w_bit;
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_rx_data <= w_rx_data;
      r_rx_done <= w_rx_done;
      r_busy    <= w_busy;
      r_cs      <= w_cs;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
    end
  end

  // Next-state logic. MISO is captured on the same edge that raises SCLK, so
  // the slave has had the whole low half (or the setup time, for the first bit)
  // to present its bit. The tx register always holds the bit currently on MOSI
  // in its MSB; it only advances on falling SCLK edges, and never after the
  // last bit, so MOSI holds the last bit through HOLD.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_bit     = r_bit;
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_rx_data = r_rx_data;
    w_rx_done = 1'b0;
    w_busy    = r_busy;
    w_cs      = r_cs;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_tx    = i_tx_data;
          w_rx    = '0;
          w_cnt   = '0;
          w_bit   = '0;
          w_cs    = 1'b0;
          w_busy  = 1'b1;
          w_mosi  = i_tx_data[DATA_WIDTH-1];
          w_state = S_SETUP;
        end
      end

      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_cnt   = '0;
          w_sclk  = 1'b1;
          w_rx    = {r_rx[DATA_WIDTH-2:0], i_spi_miso};
          w_state = S_SHIFT;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (r_cnt != HALF_LAST) begin
          w_cnt = r_cnt + CNT_W'(1);
        end else if (r_sclk) begin
          w_cnt  = '0;
          w_sclk = 1'b0;
          if (r_bit != BIT_LAST) begin
            w_tx   = {r_tx[DATA_WIDTH-2:0], 1'b0};
            w_mosi = r_tx[DATA_WIDTH-2];
          end
        end else begin
          w_cnt = '0;
          if (r_bit == BIT_LAST) begin
            w_bit   = '0;
            w_state = S_HOLD;
          end else begin
            w_bit  = r_bit + BIT_W'(1);
            w_sclk = 1'b1;
            w_rx   = {r_rx[DATA_WIDTH-2:0], i_spi_miso};
          end
        end
      end

      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt     = '0;
          w_cs      = 1'b1;
          w_mosi    = 1'b0;
          w_rx_data = r_rx;
          w_rx_done = 1'b1;
          w_state   = S_GAP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt   = '0;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_busy     = r_busy;
  assign o_rx_data  = r_rx_data;
  assign o_rx_done  = r_rx_done;
  assign o_spi_cs   = r_cs;
  assign o_spi_clk  = r_sclk;
  assign o_spi_mosi = r_mosi;

endmodule
